// File: rtl/calc_disp_pkg.sv
// Shared definitions for the calculator display path: digit count,
// segment encodings, scan FSM states and the polarity helper.
package calc_disp_pkg;

    localparam int N_DIGITS = 8;

    // Segment code meaning "nothing lit", before panel polarity is applied.
    localparam logic [7:0] SEG_OFF_CODE = 8'h00;

    typedef enum logic [1:0] {
        START = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    // Converts an active-high pattern into the level the panel expects.
    function automatic logic [7:0] apply_pol(input logic [7:0] code, input logic active_low);
        return active_low ? ~code : code;
    endfunction

endpackage

// File: rtl/disp_slot_timer.sv
// Slot/frame timebase for the display scanner. cnt walks through one digit
// slot and idx selects the digit. The timer holds at zero while run is low,
// so the first slot starts cleanly after the scanner's START cycle.
// idx_next and in_blank describe the cycle that follows the coming edge, so
// the caller can register outputs that line up with the timer position.
module disp_slot_timer #(
    parameter int CLK_PER_DIGIT = 50000,
    parameter int BLANK_CYCLES  = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    output logic [2:0] idx_next,
    output logic       slot_end,
    output logic       frame_end,
    output logic       in_blank
);

    localparam int CW = $clog2(CLK_PER_DIGIT);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_PER_DIGIT - 1);
    localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [2:0]    idx;

    assign slot_end  = run && (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == 3'd7);

    // Next slot position: hold at zero when stopped, wrap at slot end.
    always_comb begin
        cnt_next = cnt;
        idx_next = idx;
        if (!run) begin
            cnt_next = '0;
            idx_next = 3'd0;
        end else if (slot_end) begin
            cnt_next = '0;
            idx_next = idx + 3'd1;
        end else begin
            cnt_next = cnt + CW'(1);
        end
    end

    assign in_blank = (cnt_next < BLANK_LIM);

    // Slot counter and digit index registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt <= '0;
            idx <= 3'd0;
        end else begin
            cnt <= cnt_next;
            idx <= idx_next;
        end
    end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexes eight seven-segment digit codes onto one shared segment
// bus with one-hot digit selects. Inputs are captured once per frame so a
// frame never mixes old and new values, and each slot opens with a blanking
// gap so the previous digit's segments never ghost onto the next one.
// All outputs are registered from next-cycle values, so they change on the
// same edge as the state they describe.
module display_scan_mux
    import calc_disp_pkg::*;
#(
    parameter int CLK_PER_DIGIT  = 50000,
    parameter int BLANK_CYCLES   = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  d0,
    input  logic [7:0]  d1,
    input  logic [7:0]  d2,
    input  logic [7:0]  d3,
    input  logic [7:0]  d4,
    input  logic [7:0]  d5,
    input  logic [7:0]  d6,
    input  logic [7:0]  d7,
    input  logic [7:0]  digit_en,
    output logic [7:0]  seg,
    output logic [7:0]  an,
    output logic        frame_start,
    output scan_state_t dbg_state
);

    scan_state_t state;
    scan_state_t state_next;

    logic [7:0] din    [N_DIGITS];
    logic [7:0] snap_d [N_DIGITS];
    logic [7:0] snap_en;

    logic [2:0] idx_next;
    logic       slot_end;
    logic       frame_end;
    logic       in_blank;
    logic       load;

    logic [7:0] sel_code;
    logic       sel_en;
    logic       show;
    logic [7:0] an_next;
    logic [7:0] seg_next;

    assign din[0] = d0;
    assign din[1] = d1;
    assign din[2] = d2;
    assign din[3] = d3;
    assign din[4] = d4;
    assign din[5] = d5;
    assign din[6] = d6;
    assign din[7] = d7;

    assign dbg_state = state;

    disp_slot_timer #(
        .CLK_PER_DIGIT (CLK_PER_DIGIT),
        .BLANK_CYCLES  (BLANK_CYCLES)
    ) u_timer (
        .clock     (clock),
        .reset     (reset),
        .run       (state != START),
        .idx_next  (idx_next),
        .slot_end  (slot_end),
        .frame_end (frame_end),
        .in_blank  (in_blank)
    );

    // Scan FSM next state: START once after reset, then BLANK/SHOW per slot.
    always_comb begin
        state_next = state;
        case (state)
            START:   state_next = BLANK;
            BLANK:   state_next = in_blank ? BLANK : SHOW;
            SHOW:    state_next = slot_end ? BLANK : SHOW;
            default: state_next = START;
        endcase
    end

    // Snapshot reloads on the START edge and on every frame boundary.
    assign load = (state == START) || frame_end;

    // Output values for the coming cycle, taken from the snapshot in effect then.
    always_comb begin
        sel_code = load ? din[idx_next]      : snap_d[idx_next];
        sel_en   = load ? digit_en[idx_next] : snap_en[idx_next];
        show     = (state_next == SHOW) && sel_en;
        an_next  = apply_pol(show ? (8'h01 << idx_next) : 8'h00, AN_ACTIVE_LOW);
        seg_next = apply_pol(show ? sel_code : SEG_OFF_CODE, SEG_ACTIVE_LOW);
    end

    // State, snapshot and output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= START;
            snap_en     <= 8'h00;
            an          <= apply_pol(8'h00, AN_ACTIVE_LOW);
            seg         <= apply_pol(SEG_OFF_CODE, SEG_ACTIVE_LOW);
            frame_start <= 1'b0;
            for (int i = 0; i < N_DIGITS; i++) begin
                snap_d[i] <= 8'h00;
            end
        end else begin
            state       <= state_next;
            an          <= an_next;
            seg         <= seg_next;
            frame_start <= load;
            if (load) begin
                snap_en <= digit_en;
                for (int i = 0; i < N_DIGITS; i++) begin
                    snap_d[i] <= din[i];
                end
            end
        end
    end

endmodule

// File: doc/display_scan_mux.md
Name: display_scan_mux

Overview:
- Downstream stage of the calculator top level.
- Consumes the eight 8-bit seven-segment digit codes (d0..d7; bits [6:0]=g..a, bit 7=dp, e.g. "1"=8'h06, "3"=8'h4F).
- Time-multiplexes them onto one shared segment bus plus eight digit-select lines for a physical multiplexed 8-digit display.
- Snapshots inputs once per frame (no tearing) and inserts a blanking gap between digits (no ghosting).

Parameters:
- CLK_PER_DIGIT, 50000: clock cycles per digit slot. Legal range 4..2^20.
- BLANK_CYCLES, 4: cycles at the start of each slot with all digits off. Must be 1..CLK_PER_DIGIT-1.
- SEG_ACTIVE_LOW, 1: 1 = seg output inverted (common-anode panel); 0 = pass-through.
- AN_ACTIVE_LOW, 1: 1 = selected digit line driven 0; 0 = driven 1.

Ports:
- clock, input, 1: single system clock; all logic on its rising edge.
- reset, input, 1: synchronous, active-low reset.
- d0..d7, input, 8 each: segment codes from the calculator. d0 = rightmost digit.
- digit_en, input, 8: per-digit enable. Bit i=0 keeps digit i dark for its whole slot.
- seg, output, 8: shared segment bus (dp + g..a), polarity per SEG_ACTIVE_LOW.
- an, output, 8: one-hot digit select, polarity per AN_ACTIVE_LOW.
- frame_start, output, 1: one-cycle pulse on the first cycle of each frame.

Behaviour:
- Reset (reset=0 at a rising edge):
  - an = all inactive; seg = all-off pattern; frame_start=0.
  - idx=0, cnt=0, snapshot regs cleared, state=START.
  - Applies regardless of current state.
- All outputs are registered; no combinational path from inputs to outputs.
- Slot timing:
  - cnt counts 0..CLK_PER_DIGIT-1 within a slot; idx counts 0..7.
  - Frame = 8 slots = 8*CLK_PER_DIGIT cycles, fixed regardless of digit_en.
  - At cnt=CLK_PER_DIGIT-1, cnt wraps to 0 and idx increments, 7 -> 0.
- FSM states: START, BLANK, SHOW.
  - START: the first edge after reset release. Loads snapshot (d0..d7, digit_en), asserts frame_start, goes to BLANK with idx=0, cnt=0.
  - BLANK: for cnt < BLANK_CYCLES: an all inactive, seg all-off. At cnt=BLANK_CYCLES-1 -> SHOW.
  - SHOW: an[idx] active only if snap_en[idx]=1, otherwise all inactive. seg = snap_d[idx] (after polarity) when enabled, all-off when disabled. At slot end -> BLANK.
  - Slot end on idx=7 is a frame boundary: snapshot reloads on that same edge and frame_start pulses with the first BLANK cycle of slot 0.
- Input changes mid-frame never appear before the next frame boundary.
- At most one an bit is active on any cycle. There are at least BLANK_CYCLES all-off cycles between any two different active digits.
- Reset asserted mid-slot: outputs blank on the next edge; timing restarts from START after release.

Decomposition:
- Package calc_disp_pkg holds:
  - N_DIGITS=8
  - SEG_OFF_CODE = 8'h00 (pre-polarity)
  - typedef enum {START, BLANK, SHOW} scan_state_t
  - function apply_pol(code, active_low)
- One natural sub-module: disp_slot_timer. It owns cnt/idx and emits slot_end, frame_end and in_blank. The top level holds the FSM, snapshot and output registers.

Test Plan (CLK_PER_DIGIT=8, BLANK_CYCLES=2, both polarities active-low):
- Reset: hold reset=0 for 3 cycles with d0=8'h06 -> an=8'hFF, seg=8'hFF, frame_start=0 throughout.
- Basic scan: d0=8'h06, d1=8'h5B, d2..d7=8'h00, digit_en=8'hFF, release reset.
  - Edge 1 after release: frame_start=1, an=FF.
  - Slot 0, cycles 2..7: an=8'hFE, seg=8'hF9.
  - Slot 1, cycles 2..7: an=8'hFD, seg=8'hA4.
  - frame_start repeats every 64 cycles.
- Snapshot: change d0 from 8'h06 to 8'h7F during slot 3.
  - Current frame continues to show seg=F9 for slot 0.
  - Next frame slot 0 shows seg=8'h80.
- Digit mask: digit_en=8'h0F.
  - Slots 4..7: an=8'hFF, seg=8'hFF for all 8 cycles.
  - Slots 0..3 unchanged; frame period still 64 cycles.
- Blanking check: scan all slots.
  - Exactly 2 cycles with an=8'hFF at every slot boundary.
  - an is never multi-hot; checked with a $onehot0 assertion on ~an.
- Mid-operation reset: reset=0 for 1 cycle during slot 5 SHOW.
  - Next edge: an=FF, seg=FF.
  - After release: START -> frame_start pulse -> slot 0 displays current d0.
